// File: rtl/n3_sort_pkg.sv
// n3_sort_pkg
// Shared definitions for the 4-element, 3-bit bubble sorter and its comparator:
// element geometry, the pass/index limits of the bubble sweep and the FSM
// state encoding.
// Optional feature macro used by the sorter: N3_B2_SORTER_EARLY_EXIT_EN.
package n3_sort_pkg;

  localparam int ELEM_W = 3;
  localparam int ELEM_N = 4;
  localparam int DATA_W = ELEM_W * ELEM_N;

  // Three passes (p = 0..2), three adjacent compares per pass (j = 0..2).
  localparam logic [1:0] LAST_PASS = 2'd2;
  localparam logic [1:0] LAST_IDX  = 2'd2;

  typedef logic [ELEM_W-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/n3_b2_comparator.sv
// n3_b2_comparator
// Purely combinational 3-bit unsigned magnitude comparator.
// Ports:
//   a, b     in   operands (unsigned)
//   flag_gr  out  a > b
//   flag_lr  out  a < b
module n3_b2_comparator
  import n3_sort_pkg::*;
(
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic              flag_gr,
  output logic              flag_lr
);

  assign flag_gr = (a > b);
  assign flag_lr = (a < b);

endmodule

// File: rtl/n3_b2_sorter.sv
// n3_b2_sorter
// Sequential bubble sort of four 3-bit unsigned elements, one compare/swap
// per clock through a single shared comparator.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   load din and begin sorting (accepted in IDLE or DONE only)
//   din    in   element i at din[3i+2:3i]
//   busy   out  high while in SORT
//   done   out  one-cycle pulse when dout is updated
//   dout   out  sorted result, element 0 = min (max when DESCENDING=1)
// Parameter DESCENDING: 0 ascending, 1 descending.
// Macro N3_B2_SORTER_EARLY_EXIT_EN: finish as soon as a full pass makes no swap.
module n3_b2_sorter
  import n3_sort_pkg::*;
#(
  parameter bit DESCENDING = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dout
);

  state_t            state_q, state_d;
  elem_t             r_q [ELEM_N];
  elem_t             r_d [ELEM_N];
  logic [1:0]        p_q, p_d;
  logic [1:0]        j_q, j_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  elem_t cmp_a, cmp_b;
  logic  flag_gr, flag_lr;
  logic  do_swap;
  logic  last_pass_hit;

`ifdef N3_B2_SORTER_EARLY_EXIT_EN
  logic swapped_q, swapped_d;
`endif

  // Route the adjacent pair selected by j to the single comparator.
  always_comb begin
    cmp_a = r_q[0];
    cmp_b = r_q[1];
    unique case (j_q)
      2'd0:    begin cmp_a = r_q[0]; cmp_b = r_q[1]; end
      2'd1:    begin cmp_a = r_q[1]; cmp_b = r_q[2]; end
      2'd2:    begin cmp_a = r_q[2]; cmp_b = r_q[3]; end
      default: begin cmp_a = r_q[2]; cmp_b = r_q[3]; end
    endcase
  end

  n3_b2_comparator u_cmp (
    .a       (cmp_a),
    .b       (cmp_b),
    .flag_gr (flag_gr),
    .flag_lr (flag_lr)
  );

  // Strict comparison in both directions, so equal elements never swap.
  assign do_swap = DESCENDING ? flag_lr : flag_gr;

  // The sweep ends after the last pass, or earlier when a whole pass was clean.
`ifdef N3_B2_SORTER_EARLY_EXIT_EN
  assign last_pass_hit = (p_q == LAST_PASS) || !(swapped_q || do_swap);
`else
  assign last_pass_hit = (p_q == LAST_PASS);
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    p_d     = p_q;
    j_d     = j_q;
    dout_d  = dout_q;
`ifdef N3_B2_SORTER_EARLY_EXIT_EN
    swapped_d = swapped_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          for (int i = 0; i < ELEM_N; i++) begin
            r_d[i] = din[i*ELEM_W +: ELEM_W];
          end
          p_d     = 2'd0;
          j_d     = 2'd0;
          state_d = SORT;
`ifdef N3_B2_SORTER_EARLY_EXIT_EN
          swapped_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      SORT: begin
        if (do_swap) begin
          unique case (j_q)
            2'd0:    begin r_d[0] = r_q[1]; r_d[1] = r_q[0]; end
            2'd1:    begin r_d[1] = r_q[2]; r_d[2] = r_q[1]; end
            default: begin r_d[2] = r_q[3]; r_d[3] = r_q[2]; end
          endcase
        end
`ifdef N3_B2_SORTER_EARLY_EXIT_EN
        swapped_d = swapped_q | do_swap;
`endif
        if (j_q == LAST_IDX) begin
          j_d = 2'd0;
`ifdef N3_B2_SORTER_EARLY_EXIT_EN
          swapped_d = 1'b0;
`endif
          if (last_pass_hit) begin
            // Capture the post-swap contents so the final compare is included.
            state_d = DONE;
            for (int i = 0; i < ELEM_N; i++) begin
              dout_d[i*ELEM_W +: ELEM_W] = r_d[i];
            end
          end else begin
            p_d = p_q + 2'd1;
          end
        end else begin
          j_d = j_q + 2'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '{default: '0};
      p_q     <= 2'd0;
      j_q     <= 2'd0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      p_q     <= p_d;
      j_q     <= j_d;
      dout_q  <= dout_d;
    end
  end

`ifdef N3_B2_SORTER_EARLY_EXIT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) swapped_q <= 1'b0;
    else       swapped_q <= swapped_d;
  end
`endif

  assign busy = (state_q == SORT);
  assign done = (state_q == DONE);
  assign dout = dout_q;

endmodule
